// File: rtl/dff_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared-register write arbiter.
// Supports up to RR_MAX_N requesters.
package dff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam int RR_MAX_N = 32;

    // First set bit of req[n-1:0], scanning from ptr upward and wrapping to 0.
    function automatic logic [4:0] rr_pick(
        input logic [31:0] req,
        input logic [4:0]  ptr,
        input logic [5:0]  n
    );
        logic [4:0] pick;
        logic       found;
        logic [5:0] idx;
        pick  = 5'd0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX_N; k++) begin
            idx = {1'b0, ptr} + k[5:0];
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k[5:0] < n) && !found && req[idx[4:0]]) begin
                pick  = idx[4:0];
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_dff_reg.sv
// W-bit D register with write enable, synchronous active-low clear and
// a complementary output that always tracks the true output.
module shared_dff_reg #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] Q,
    output logic [W-1:0] Q_n
);

    logic [W-1:0] r_q;

    // Storage: clear wins over any enabled write.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_q <= {W{1'b0}};
        end else if (en) begin
            r_q <= d;
        end else begin
            r_q <= r_q;
        end
    end

    assign Q   = r_q;
    assign Q_n = ~r_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter granting one of N requesters exclusive write access to a
// shared W-bit register, with bounded hold time and a mandatory idle turnaround.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [W-1:0]         Q,
    output logic [W-1:0]         Q_n
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic [PW-1:0] r_owner;
    logic [PW-1:0] w_owner_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic [PW-1:0] w_pick;
    logic          w_owner_req;
    logic          w_wr_en;
    logic [W-1:0]  w_wr_data;

    assign w_pick      = PW'(rr_pick(32'(req), 5'(r_ptr), 6'(N)));
    assign w_owner_req = req[r_owner];
    assign w_wr_en     = r_busy & w_owner_req;
    assign w_wr_data   = wdata[r_owner*W +: W];

    // Next-state and next-output decode for the grant FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_busy_nxt  = r_busy;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = OWN;
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick;
                    w_owner_nxt = w_pick;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = {HW{1'b0}};
                end else begin
                    w_gnt_nxt   = {N{1'b0}};
                end
            end
            OWN: begin
                // Release on dropped request or on the write that reaches MAX_HOLD.
                if (w_owner_req && (r_hold != HW'(MAX_HOLD - 1))) begin
                    w_hold_nxt = r_hold + HW'(1);
                end else begin
                    w_hold_nxt  = w_owner_req ? r_hold + HW'(1) : r_hold;
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = {N{1'b0}};
                    w_busy_nxt  = 1'b0;
                    w_ptr_nxt   = (r_owner == PW'(N - 1)) ? {PW{1'b0}} : r_owner + PW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = {N{1'b0}};
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // FSM and arbitration state registers.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_gnt   <= {N{1'b0}};
            r_owner <= {PW{1'b0}};
            r_busy  <= 1'b0;
            r_ptr   <= {PW{1'b0}};
            r_hold  <= {HW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_busy  <= w_busy_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    shared_dff_reg #(
        .W (W)
    ) u_reg (
        .CLK   (CLK),
        .RST_n (RST_n),
        .en    (w_wr_en),
        .d     (w_wr_data),
        .Q     (Q),
        .Q_n   (Q_n)
    );

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = r_busy;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter (N=4, W=8, MAX_HOLD=4): per-cycle
// expectations are queued before each edge and compared just after it.
module tb_dff_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           RST_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   Q;
    logic [W-1:0]   Q_n;

    int checks = 0;
    int errors = 0;
    int step   = 0;
    logic [7:0] lastq;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic [7:0] q;
    } exp_t;

    exp_t sb[$];

    dff_write_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .Q     (Q),
        .Q_n   (Q_n)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic b, input logic [1:0] o, input logic [7:0] q);
        exp_t e;
        e.gnt   = g;
        e.busy  = b;
        e.owner = o;
        e.q     = q;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [7:0] qn;
        @(posedge CLK);
        #1;
        step++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty step=%0d observed=0 expected=1", step);
        end else begin
            e  = sb.pop_front();
            qn = ~e.q;
            chk("gnt",   32'(gnt),   32'(e.gnt));
            chk("busy",  32'(busy),  32'(e.busy));
            chk("owner", 32'(owner), 32'(e.owner));
            chk("q",     32'(Q),     32'(e.q));
            chk("q_n",   32'(Q_n),   32'(qn));
        end
    endtask

    task automatic setw(input int i, input logic [7:0] v);
        wdata[i*W +: W] = v;
    endtask

    initial begin
        // Reset held for two edges with every requester asking.
        RST_n = 1'b0;
        req   = 4'hF;
        wdata = {(N*W){1'b0}};
        push(4'b0000, 1'b0, 2'd0, 8'h00); tick();
        push(4'b0000, 1'b0, 2'd0, 8'h00); tick();

        // Single requester 2: grant, four writes, one idle, regrant, drop.
        RST_n = 1'b1;
        req   = 4'b0100;
        setw(2, 8'hA5);
        push(4'b0100, 1'b1, 2'd2, 8'h00); tick();
        push(4'b0100, 1'b1, 2'd2, 8'hA5); tick();
        setw(2, 8'hA6);
        push(4'b0100, 1'b1, 2'd2, 8'hA6); tick();
        setw(2, 8'hA7);
        push(4'b0100, 1'b1, 2'd2, 8'hA7); tick();
        setw(2, 8'hA8);
        push(4'b0000, 1'b0, 2'd2, 8'hA8); tick();
        setw(2, 8'hB0);
        push(4'b0100, 1'b1, 2'd2, 8'hA8); tick();
        req = 4'b0000;
        push(4'b0000, 1'b0, 2'd2, 8'hA8); tick();

        // Reset to bring the round-robin pointer back to 0.
        RST_n = 1'b0;
        push(4'b0000, 1'b0, 2'd0, 8'h00); tick();
        RST_n = 1'b1;

        // All four requesting: order 0,1,2,3,0, four writes each.
        req = 4'hF;
        for (int i = 0; i < N; i++) setw(i, 8'h10 + i[7:0]);
        lastq = 8'h00;
        for (int o = 0; o < N; o++) begin
            push(4'b0001 << o, 1'b1, o[1:0], lastq); tick();
            for (int k = 0; k < 4; k++) begin
                push((k < 3) ? (4'b0001 << o) : 4'b0000, (k < 3), o[1:0], 8'h10 + o[7:0]);
                tick();
            end
            lastq = 8'h10 + o[7:0];
        end
        push(4'b0001, 1'b1, 2'd0, 8'h13); tick();
        for (int k = 0; k < 4; k++) begin
            push((k < 3) ? 4'b0001 : 4'b0000, (k < 3), 2'd0, 8'h10);
            tick();
        end

        // Owner 3 drops after two writes while requester 0 waits; pointer wraps.
        req = 4'b1001;
        push(4'b1000, 1'b1, 2'd3, 8'h10); tick();
        push(4'b1000, 1'b1, 2'd3, 8'h13); tick();
        push(4'b1000, 1'b1, 2'd3, 8'h13); tick();
        req = 4'b0001;
        setw(3, 8'h33);
        push(4'b0000, 1'b0, 2'd3, 8'h13); tick();
        push(4'b0001, 1'b1, 2'd0, 8'h13); tick();

        // Reset mid-ownership with an owner write pending.
        setw(0, 8'h55);
        RST_n = 1'b0;
        push(4'b0000, 1'b0, 2'd0, 8'h00); tick();
        RST_n = 1'b1;

        // Requester 1 owns; non-owner data is X or toggling and must be ignored.
        req   = 4'b1010;
        wdata = {(N*W){1'bx}};
        setw(1, 8'hC3);
        push(4'b0010, 1'b1, 2'd1, 8'h00); tick();
        push(4'b0010, 1'b1, 2'd1, 8'hC3); tick();
        setw(0, 8'hFF); setw(2, 8'h00); setw(3, 8'hEE);
        setw(1, 8'h3C);
        push(4'b0010, 1'b1, 2'd1, 8'h3C); tick();
        wdata = {(N*W){1'bx}};
        setw(1, 8'h5A);
        push(4'b0010, 1'b1, 2'd1, 8'h5A); tick();
        req   = 4'b1000;
        wdata = {(N*W){1'bx}};
        push(4'b0000, 1'b0, 2'd1, 8'h5A); tick();
        push(4'b1000, 1'b1, 2'd3, 8'h5A); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
